// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1-style TAP controller clocked by TCK (clk).
// Holds the 16-state TAP FSM, the 4-bit instruction shift/update register
// pair, the 1-bit bypass register and the TDO output mux.
// Optional feature macro: JTAG_IDCODE_EN adds a 32-bit IDCODE data register
// selected by opcode 1111, and forces the reset instruction to 1111.
module jtag_tap_ctrl #(
   parameter int              IR_W       = 4,
   parameter logic [IR_W-1:0] IR_RST     = 4'b0000,
   parameter logic [31:0]     IDCODE_VAL = 32'h1000_0001
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tms,
   input  logic            tdi,
   input  logic            dr_tdo,
   input  logic            dr_ext_sel,
   output logic            tdo,
   output logic            tdo_en,
   output logic [IR_W-1:0] ir_out,
   output logic [3:0]      tap_state,
   output logic            tlr,
   output logic            capture_dr,
   output logic            shift_dr,
   output logic            update_dr,
   output logic            shift_ir
);

   typedef enum logic [3:0] {
      TLR   = 4'hF,
      RTI   = 4'hC,
      SELDR = 4'h7,
      CAPDR = 4'h6,
      SHDR  = 4'h2,
      EX1DR = 4'h1,
      PADR  = 4'h3,
      EX2DR = 4'h0,
      UPDR  = 4'h5,
      SELIR = 4'h4,
      CAPIR = 4'hE,
      SHIR  = 4'hA,
      EX1IR = 4'h9,
      PAIR  = 4'hB,
      EX2IR = 4'h8,
      UPIR  = 4'hD
   } state_t;

   localparam logic [IR_W-1:0] IDCODE_OP = {IR_W{1'b1}};

`ifdef JTAG_IDCODE_EN
   // With IDCODE present the device must come out of reset selecting it.
   localparam logic [IR_W-1:0] IR_RST_EFF = {IR_W{1'b1}};
   logic unused_ir_rst;
   assign unused_ir_rst = ^IR_RST;
`else
   localparam logic [IR_W-1:0] IR_RST_EFF = IR_RST;
   logic unused_idcode;
   assign unused_idcode = ^IDCODE_VAL;
`endif

   state_t            state;
   logic [IR_W-1:0]   ir_sr;
   logic [IR_W-1:0]   ir_reg;
   logic              byp;
   logic              id_sel;
   logic              id_bit;

   // TAP state machine: walks the 1149.1 graph on tms, reset wins over tms.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= TLR;
      end else begin
         case (state)
            TLR:   state <= tms ? TLR   : RTI;
            RTI:   state <= tms ? SELDR : RTI;
            SELDR: state <= tms ? SELIR : CAPDR;
            CAPDR: state <= tms ? EX1DR : SHDR;
            SHDR:  state <= tms ? EX1DR : SHDR;
            EX1DR: state <= tms ? UPDR  : PADR;
            PADR:  state <= tms ? EX2DR : PADR;
            EX2DR: state <= tms ? UPDR  : SHDR;
            UPDR:  state <= tms ? SELDR : RTI;
            SELIR: state <= tms ? TLR   : CAPIR;
            CAPIR: state <= tms ? EX1IR : SHIR;
            SHIR:  state <= tms ? EX1IR : SHIR;
            EX1IR: state <= tms ? UPIR  : PAIR;
            PAIR:  state <= tms ? EX2IR : PAIR;
            EX2IR: state <= tms ? UPIR  : SHIR;
            UPIR:  state <= tms ? SELDR : RTI;
            default: state <= state;
         endcase
      end
   end

   // Instruction shift register: capture the 01 pattern, shift LSB first.
   always_ff @(posedge clk) begin
      if (rst) begin
         ir_sr <= '0;
      end else if (state == CAPIR) begin
         ir_sr <= {{(IR_W-2){1'b0}}, 2'b01};
      end else if (state == SHIR) begin
         ir_sr <= {tdi, ir_sr[IR_W-1:1]};
      end
   end

   // Instruction update register: only changes in UPIR, TLR or reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ir_reg <= IR_RST_EFF;
      end else if (state == TLR) begin
         ir_reg <= IR_RST_EFF;
      end else if (state == UPIR) begin
         ir_reg <= ir_sr;
      end
   end

   // Bypass register: cleared on capture, one-cycle tdi delay while shifting.
   always_ff @(posedge clk) begin
      if (rst) begin
         byp <= 1'b0;
      end else if (state == CAPDR) begin
         byp <= 1'b0;
      end else if (state == SHDR) begin
         byp <= tdi;
      end
   end

`ifdef JTAG_IDCODE_EN
   logic [31:0] id_sr;

   // IDCODE register: loads the device ID on capture, shifts right from tdi.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_sr <= '0;
      end else if (ir_reg == IDCODE_OP) begin
         if (state == CAPDR) begin
            id_sr <= IDCODE_VAL;
         end else if (state == SHDR) begin
            id_sr <= {tdi, id_sr[31:1]};
         end
      end
   end

   assign id_sel = (ir_reg == IDCODE_OP);
   assign id_bit = id_sr[0];
`else
   assign id_sel = 1'b0;
   assign id_bit = 1'b0;
`endif

   // TDO mux: IR in SHIR, otherwise the selected DR in SHDR, else driven low.
   always_comb begin
      tdo = 1'b0;
      if (state == SHIR) begin
         tdo = ir_sr[0];
      end else if (state == SHDR) begin
         if (id_sel) begin
            tdo = id_bit;
         end else if (dr_ext_sel) begin
            tdo = dr_tdo;
         end else begin
            tdo = byp;
         end
      end
   end

   assign tdo_en     = (state == SHDR) || (state == SHIR);
   assign ir_out     = ir_reg;
   assign tap_state  = state;
   assign tlr        = (state == TLR);
   assign capture_dr = (state == CAPDR);
   assign shift_dr   = (state == SHDR);
   assign update_dr  = (state == UPDR);
   assign shift_ir   = (state == SHIR);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: self-checking bench for jtag_tap_ctrl.
// Directed scenarios plus a randomized walk checked against a table-driven
// reference model. Honors JTAG_IDCODE_EN the same way as the design.
module tb_jtag_tap_ctrl;

`ifdef JTAG_IDCODE_EN
   localparam logic [3:0] EXP_IR_RST = 4'hF;
`else
   localparam logic [3:0] EXP_IR_RST = 4'h0;
`endif
   localparam logic [31:0] EXP_IDCODE = 32'h1000_0001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tms = 1'b0;
   logic       tdi = 1'b0;
   logic       dr_tdo = 1'b0;
   logic       dr_ext_sel = 1'b0;
   logic       tdo;
   logic       tdo_en;
   logic [3:0] ir_out;
   logic [3:0] tap_state;
   logic       tlr;
   logic       capture_dr;
   logic       shift_dr;
   logic       update_dr;
   logic       shift_ir;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model: next-state tables indexed by state code
   logic [3:0]  nxt0 [16];
   logic [3:0]  nxt1 [16];
   logic [3:0]  m_state;
   logic [3:0]  m_ir_reg;
   logic [3:0]  m_ir_sr;
   logic        m_byp;
   logic [31:0] m_id;

   jtag_tap_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .tms        (tms),
      .tdi        (tdi),
      .dr_tdo     (dr_tdo),
      .dr_ext_sel (dr_ext_sel),
      .tdo        (tdo),
      .tdo_en     (tdo_en),
      .ir_out     (ir_out),
      .tap_state  (tap_state),
      .tlr        (tlr),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .shift_ir   (shift_ir)
   );

   always #5 clk = ~clk;

   task automatic init_tables();
      // {code, next on tms=0, next on tms=1}
      logic [11:0] tbl [16];
      tbl = '{12'hFCF, 12'hCC7, 12'h764, 12'h621, 12'h221, 12'h135,
              12'h330, 12'h025, 12'h5C7, 12'h4EF, 12'hEA9, 12'hAA9,
              12'h9BD, 12'hBB8, 12'h8AD, 12'hDC7};
      for (int i = 0; i < 16; i++) begin
         nxt0[tbl[i][11:8]] = tbl[i][7:4];
         nxt1[tbl[i][11:8]] = tbl[i][3:0];
      end
   endtask

   function automatic logic model_tdo(input logic ext, input logic ext_bit);
      if (m_state == 4'hA) return m_ir_sr[0];
      if (m_state == 4'h2) begin
`ifdef JTAG_IDCODE_EN
         if (m_ir_reg == 4'hF) return m_id[0];
`endif
         return ext ? ext_bit : m_byp;
      end
      return 1'b0;
   endfunction

   // drive one TCK cycle and advance the reference model alongside it
   task automatic apply_stimulus(input logic r, input logic t, input logic d);
      rst = r;
      tms = t;
      tdi = d;
      if (r) begin
         m_state  = 4'hF;
         m_ir_reg = EXP_IR_RST;
         m_ir_sr  = 4'h0;
         m_byp    = 1'b0;
      end else begin
         if (m_state == 4'hF) m_ir_reg = EXP_IR_RST;
         if (m_state == 4'hE) m_ir_sr = 4'b0001;
         if (m_state == 4'hA) m_ir_sr = {d, m_ir_sr[3:1]};
         if (m_state == 4'hD) m_ir_reg = m_ir_sr;
         if (m_state == 4'h6) begin
            m_byp = 1'b0;
            if (m_ir_reg == 4'hF) m_id = EXP_IDCODE;
         end
         if (m_state == 4'h2) begin
            m_byp = d;
            if (m_ir_reg == 4'hF) m_id = {d, m_id[31:1]};
         end
         m_state = t ? nxt1[m_state] : nxt0[m_state];
      end
      @(posedge clk);
      #1;
   endtask

   // scan an instruction in from RTI, returning to RTI
   task automatic load_ir(input logic [3:0] v);
      apply_stimulus(0, 1, 0);
      apply_stimulus(0, 1, 0);
      apply_stimulus(0, 0, 0);
      apply_stimulus(0, 0, 0);
      for (int i = 0; i < 4; i++) apply_stimulus(0, (i == 3), v[i]);
      apply_stimulus(0, 1, 0);
      apply_stimulus(0, 0, 0);
   endtask

   task automatic test_reset();
      apply_stimulus(1, 1, 0);
      apply_stimulus(1, 0, 0);
      n_cmp++; if (tap_state !== 4'hF) begin n_fail++; $display("[TB] FAIL reset_state: got %h expected f", tap_state); end
      n_cmp++; if (tlr !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tlr: got %b expected 1", tlr); end
      n_cmp++; if (ir_out !== EXP_IR_RST) begin n_fail++; $display("[TB] FAIL reset_ir: got %h expected %h", ir_out, EXP_IR_RST); end
      n_cmp++; if (tdo_en !== 1'b0 || tdo !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tdo: got en=%b tdo=%b expected 0/0", tdo_en, tdo); end
      n_cmp++; if ({capture_dr, shift_dr, update_dr, shift_ir} !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {capture_dr, shift_dr, update_dr, shift_ir}); end
      apply_stimulus(0, 0, 0);
      n_cmp++; if (tap_state !== 4'hC) begin n_fail++; $display("[TB] FAIL reset_to_rti: got %h expected c", tap_state); end
   endtask

   task automatic test_ir_scan();
      logic [3:0] bits;
      logic [3:0] exp_tdo;
      bits = 4'b0101;
      exp_tdo = 4'b0001;
      apply_stimulus(0, 1, 0);
      apply_stimulus(0, 1, 0);
      apply_stimulus(0, 0, 0);
      apply_stimulus(0, 0, 0);
      n_cmp++; if (shift_ir !== 1'b1 || tap_state !== 4'hA) begin n_fail++; $display("[TB] FAIL ir_enter_shir: got state %h expected a", tap_state); end
      for (int i = 0; i < 4; i++) begin
         tdi = bits[i];
         #1;
         n_cmp++; if (tdo !== exp_tdo[i]) begin n_fail++; $display("[TB] FAIL ir_tdo[%0d]: got %b expected %b", i, tdo, exp_tdo[i]); end
         apply_stimulus(0, (i == 3), bits[i]);
      end
      apply_stimulus(0, 1, 0);
      n_cmp++; if (tap_state !== 4'hD || ir_out !== EXP_IR_RST) begin n_fail++; $display("[TB] FAIL ir_in_upir: got state %h ir %h expected d/%h", tap_state, ir_out, EXP_IR_RST); end
      apply_stimulus(0, 0, 0);
      n_cmp++; if (ir_out !== 4'b0101) begin n_fail++; $display("[TB] FAIL ir_after_upir: got %h expected 5", ir_out); end
   endtask

   task automatic test_bypass();
      logic [2:0] bits;
      logic [2:0] exp_tdo;
      bits = 3'b011;
      exp_tdo = 3'b110;
      load_ir(4'b0000);
      n_cmp++; if (ir_out !== 4'b0000) begin n_fail++; $display("[TB] FAIL byp_ir: got %h expected 0", ir_out); end
      dr_ext_sel = 1'b0;
      apply_stimulus(0, 1, 0);
      apply_stimulus(0, 0, 0);
      n_cmp++; if (capture_dr !== 1'b1) begin n_fail++; $display("[TB] FAIL byp_capture: got %b expected 1", capture_dr); end
      apply_stimulus(0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tdi = bits[i];
         #1;
         n_cmp++; if (tdo !== exp_tdo[i] || tdo_en !== 1'b1) begin n_fail++; $display("[TB] FAIL byp_tdo[%0d]: got %b/en %b expected %b/en 1", i, tdo, tdo_en, exp_tdo[i]); end
         apply_stimulus(0, (i == 2), bits[i]);
      end
      apply_stimulus(0, 1, 0);
      n_cmp++; if (update_dr !== 1'b1) begin n_fail++; $display("[TB] FAIL byp_update: got %b expected 1", update_dr); end
      apply_stimulus(0, 0, 0);
   endtask

   task automatic test_tlr_from_shdr();
      load_ir(4'b0101);
      apply_stimulus(0, 1, 0);
      apply_stimulus(0, 0, 0);
      apply_stimulus(0, 0, 0);
      n_cmp++; if (shift_dr !== 1'b1) begin n_fail++; $display("[TB] FAIL tlr_start_shdr: got state %h expected 2", tap_state); end
      for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0);
      n_cmp++; if (tap_state !== 4'h4) begin n_fail++; $display("[TB] FAIL tlr_after4: got %h expected 4", tap_state); end
      apply_stimulus(0, 1, 0);
      n_cmp++; if (tap_state !== 4'hF || tlr !== 1'b1) begin n_fail++; $display("[TB] FAIL tlr_after5: got %h expected f", tap_state); end
      apply_stimulus(0, 1, 0);
      n_cmp++; if (ir_out !== EXP_IR_RST) begin n_fail++; $display("[TB] FAIL tlr_ir_reset: got %h expected %h", ir_out, EXP_IR_RST); end
      apply_stimulus(0, 0, 0);
   endtask

   task automatic test_reset_mid_shift();
      logic seen_upd;
      seen_upd = 1'b0;
      apply_stimulus(0, 1, 0);
      apply_stimulus(0, 1, 0);
      apply_stimulus(0, 0, 0);
      apply_stimulus(0, 0, 1);
      n_cmp++; if (tap_state !== 4'hA) begin n_fail++; $display("[TB] FAIL rms_shir2: got %h expected a", tap_state); end
      apply_stimulus(1, 0, 1);
      n_cmp++; if (tap_state !== 4'hF) begin n_fail++; $display("[TB] FAIL rms_state: got %h expected f", tap_state); end
      n_cmp++; if (ir_out !== EXP_IR_RST) begin n_fail++; $display("[TB] FAIL rms_ir: got %h expected %h", ir_out, EXP_IR_RST); end
      for (int i = 0; i < 3; i++) begin
         seen_upd |= update_dr;
         apply_stimulus(0, 1, 0);
      end
      seen_upd |= update_dr;
      n_cmp++; if (seen_upd !== 1'b0 || ir_out !== EXP_IR_RST) begin n_fail++; $display("[TB] FAIL rms_after: got upd %b ir %h expected 0/%h", seen_upd, ir_out, EXP_IR_RST); end
      apply_stimulus(0, 0, 0);
   endtask

   task automatic test_idcode();
      logic d;
      logic prev;
      logic exp;
      apply_stimulus(1, 0, 0);
      apply_stimulus(0, 0, 0);
      apply_stimulus(0, 1, 0);
      apply_stimulus(0, 0, 0);
      apply_stimulus(0, 0, 0);
      prev = 1'b0;
      for (int i = 0; i < 32; i++) begin
         d = 1'($urandom);
`ifdef JTAG_IDCODE_EN
         dr_ext_sel = 1'($urandom);
         dr_tdo = 1'($urandom);
         exp = EXP_IDCODE[i];
`else
         dr_ext_sel = 1'b0;
         exp = prev;
`endif
         tdi = d;
         #1;
         n_cmp++; if (tdo !== exp) begin n_fail++; $display("[TB] FAIL idcode_bit[%0d]: got %b expected %b", i, tdo, exp); end
         prev = d;
         apply_stimulus(0, (i == 31), d);
      end
      apply_stimulus(0, 1, 0);
      apply_stimulus(0, 0, 0);
      dr_ext_sel = 1'b0;
   endtask

   task automatic test_random();
      logic r;
      logic t;
      logic d;
      for (int c = 0; c < 1500; c++) begin
         r = ($urandom_range(0, 99) == 0);
         t = ($urandom_range(0, 99) < 45);
         d = 1'($urandom);
         dr_ext_sel = 1'($urandom);
         dr_tdo = 1'($urandom);
         tdi = d;
         #1;
         n_cmp++; if (tap_state !== m_state) begin n_fail++; $display("[TB] FAIL rnd_state c%0d: got %h expected %h", c, tap_state, m_state); end
         n_cmp++; if (ir_out !== m_ir_reg) begin n_fail++; $display("[TB] FAIL rnd_ir c%0d: got %h expected %h", c, ir_out, m_ir_reg); end
         n_cmp++; if (tdo !== model_tdo(dr_ext_sel, dr_tdo)) begin n_fail++; $display("[TB] FAIL rnd_tdo c%0d: got %b expected %b", c, tdo, model_tdo(dr_ext_sel, dr_tdo)); end
         n_cmp++; if (tdo_en !== (m_state == 4'h2 || m_state == 4'hA)) begin n_fail++; $display("[TB] FAIL rnd_tdo_en c%0d: got %b state %h", c, tdo_en, m_state); end
         n_cmp++; if ({tlr, capture_dr, shift_dr, update_dr, shift_ir} !==
                      {m_state == 4'hF, m_state == 4'h6, m_state == 4'h2, m_state == 4'h5, m_state == 4'hA}) begin
            n_fail++; $display("[TB] FAIL rnd_strobes c%0d: got %b state %h", c, {tlr, capture_dr, shift_dr, update_dr, shift_ir}, m_state);
         end
         apply_stimulus(r, t, d);
      end
   endtask

   initial begin
      init_tables();
      m_id = '0;
      test_reset();
      test_ir_scan();
      test_bypass();
      test_tlr_from_shdr();
      test_reset_mid_shift();
      test_idcode();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
